proc_scoreboard: RTL and testbench

- Parametrised register scoreboard for the in-order TinyRV2 pipeline; successor to the fixed X/M/W hazard logic in the control unit.
- Tracks every pending register write, its pipeline position and the cycle its result becomes bypassable.
- Supports configurable depth and fixed-latency or variable-latency producers (iterative multiplier, long-latency loads).
- Sits in D: gives per-source bypass select and a stall request. The control unit uses these in place of hand-written X/M/W compares.

---
 rtl/proc_sb_pkg.sv | 23 ++
 rtl/proc_sb_entry.sv | 61 ++++++
 rtl/proc_scoreboard.sv | 104 ++++++++++
 tb/tb_proc_scoreboard.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_sb_pkg.sv
// Shared types for the TinyRV2 register scoreboard: per-register entry
// record and the bypass-select encoding for the default four-stage depth.
package proc_sb_pkg;

  localparam int SB_POS_W = 4;
  localparam int SB_CTR_W = 4;

  typedef enum logic [1:0] {
    BYP_RF = 2'd0,
    BYP_X  = 2'd1,
    BYP_M  = 2'd2,
    BYP_W  = 2'd3
  } byp_sel_e;

  typedef struct packed {
    logic                pend;
    logic                is_var;
    logic                done;
    logic [SB_POS_W-1:0] pos;
    logic [SB_CTR_W-1:0] rdy_ctr;
  } sb_entry_t;

endpackage

// File: rtl/proc_sb_entry.sv
// One scoreboard entry: owns the per-register update and its priority
// (reset > squash > issue > wb clear > advance/var_done).
module proc_sb_entry
  import proc_sb_pkg::*;
#(
  parameter int NSTAGES = 4,
  parameter int PW      = 3,
  parameter int LW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv_i,
  input  logic          squash_i,
  input  logic [PW-1:0] squashDepth_i,
  input  logic          issue_i,
  input  logic          issueVar_i,
  input  logic [LW-1:0] issueLat_i,
  input  logic          wb_i,
  input  logic          done_i,
  output logic          pend_o,
  output logic          ready_o,
  output logic          varWait_o,
  output logic [PW-1:0] pos_o
);

  sb_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (squash_i && entry_q.pend && (entry_q.pos < SB_POS_W'(squashDepth_i))) begin
      entry_d = '0;
    end else if (issue_i) begin
      entry_d.pend    = 1'b1;
      entry_d.is_var  = issueVar_i;
      entry_d.done    = 1'b0;
      entry_d.pos     = SB_POS_W'(1);
      // Latency L is bypassable after L cycles; the first one is spent reaching X.
      entry_d.rdy_ctr = (issueVar_i || (issueLat_i == '0)) ? '0
                        : SB_CTR_W'(issueLat_i) - SB_CTR_W'(1);
    end else if (wb_i && entry_q.pend && (entry_q.pos == SB_POS_W'(NSTAGES))) begin
      entry_d = '0;
    end else if (entry_q.pend) begin
      if (adv_i) begin
        if (entry_q.pos != SB_POS_W'(NSTAGES)) entry_d.pos = entry_q.pos + SB_POS_W'(1);
        if (entry_q.rdy_ctr != '0) entry_d.rdy_ctr = entry_q.rdy_ctr - SB_CTR_W'(1);
      end
      if (done_i && entry_q.is_var) entry_d.done = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign pend_o    = entry_q.pend;
  assign ready_o   = entry_q.pend && (entry_q.is_var ? entry_q.done : (entry_q.rdy_ctr == '0));
  assign varWait_o = entry_q.pend && entry_q.is_var && !entry_q.done;
  assign pos_o     = PW'(entry_q.pos);

endmodule

// File: rtl/proc_scoreboard.sv
// Register scoreboard for the TinyRV2 D stage: bypass selects and stall request.
// Define PROC_SB_STATS_EN to add the RAW/WAW stall-cycle counters.
module proc_scoreboard
  import proc_sb_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int NSTAGES = 4,
  parameter int MAX_LAT = 7,
  parameter int AW      = $clog2(NREGS),
  parameter int PW      = $clog2(NSTAGES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pipe_stall,
  input  logic                         issue_val,
  output logic                         issue_rdy,
  input  logic                         issue_wen,
  input  logic [AW-1:0]                issue_rd,
  input  logic                         issue_var,
  input  logic [$clog2(MAX_LAT+1)-1:0] issue_lat,
  input  logic                         rs1_ren,
  input  logic                         rs2_ren,
  input  logic [AW-1:0]                rs1_addr,
  input  logic [AW-1:0]                rs2_addr,
  output logic [PW-1:0]                rs1_byp_sel,
  output logic [PW-1:0]                rs2_byp_sel,
  output logic                         stall,
  input  logic                         var_done_val,
  input  logic [AW-1:0]                var_done_rd,
  input  logic                         wb_val,
  input  logic [AW-1:0]                wb_rd,
  input  logic                         squash_val,
  input  logic [PW-1:0]                squash_depth
`ifdef PROC_SB_STATS_EN
  ,
  output logic [31:0]                  raw_stall_cnt,
  output logic [31:0]                  waw_stall_cnt
`endif
);

  localparam int LW = $clog2(MAX_LAT + 1);

  logic [NREGS-1:0] pendVec, readyVec, varWaitVec;
  logic [PW-1:0]    posArr [NREGS];
  logic             rs1Hit, rs2Hit, rs1Stall, rs2Stall, wawStall, issueAcc;

  // Squash takes precedence over a same-cycle issue; x0 never becomes pending.
  assign issueAcc = issue_val && !stall && !pipe_stall && !squash_val &&
                    issue_wen && (issue_rd != '0);

  for (genvar r = 0; r < NREGS; r++) begin : g_entry
    proc_sb_entry #(
      .NSTAGES(NSTAGES),
      .PW     (PW),
      .LW     (LW)
    ) u_entry (
      .clk          (clk),
      .reset        (reset),
      .adv_i        (!pipe_stall),
      .squash_i     (squash_val),
      .squashDepth_i(squash_depth),
      .issue_i      (issueAcc && (issue_rd == AW'(r))),
      .issueVar_i   (issue_var),
      .issueLat_i   (issue_lat),
      .wb_i         (wb_val && (wb_rd == AW'(r))),
      .done_i       (var_done_val && (var_done_rd == AW'(r))),
      .pend_o       (pendVec[r]),
      .ready_o      (readyVec[r]),
      .varWait_o    (varWaitVec[r]),
      .pos_o        (posArr[r])
    );
  end

  always_comb begin
    rs1Hit      = rs1_ren && (rs1_addr != '0) && pendVec[rs1_addr];
    rs2Hit      = rs2_ren && (rs2_addr != '0) && pendVec[rs2_addr];
    rs1Stall    = rs1Hit && !readyVec[rs1_addr];
    rs2Stall    = rs2Hit && !readyVec[rs2_addr];
    rs1_byp_sel = (rs1Hit && readyVec[rs1_addr]) ? posArr[rs1_addr] : PW'(BYP_RF);
    rs2_byp_sel = (rs2Hit && readyVec[rs2_addr]) ? posArr[rs2_addr] : PW'(BYP_RF);
    wawStall    = issue_wen && (issue_rd != '0) && varWaitVec[issue_rd];
  end

  assign stall     = rs1Stall || rs2Stall || wawStall;
  assign issue_rdy = !stall;

`ifdef PROC_SB_STATS_EN
  logic [31:0] rawStallCnt_q, wawStallCnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rawStallCnt_q <= '0;
      wawStallCnt_q <= '0;
    end else begin
      if (issue_val && (rs1Stall || rs2Stall)) rawStallCnt_q <= rawStallCnt_q + 32'd1;
      if (issue_val && wawStall)               wawStallCnt_q <= wawStallCnt_q + 32'd1;
    end
  end

  assign raw_stall_cnt = rawStallCnt_q;
  assign waw_stall_cnt = wawStallCnt_q;
`endif

endmodule

// File: tb/tb_proc_scoreboard.sv
// Directed self-checking bench for proc_scoreboard at default depth (NSTAGES=4).
// Stats counters are checked only when PROC_SB_STATS_EN is defined.
module tb_proc_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       pipe_stall;
  logic       issue_val;
  logic       issue_rdy;
  logic       issue_wen;
  logic [4:0] issue_rd;
  logic       issue_var;
  logic [2:0] issue_lat;
  logic       rs1_ren, rs2_ren;
  logic [4:0] rs1_addr, rs2_addr;
  logic [2:0] rs1_byp_sel, rs2_byp_sel;
  logic       stall;
  logic       var_done_val;
  logic [4:0] var_done_rd;
  logic       wb_val;
  logic [4:0] wb_rd;
  logic       squash_val;
  logic [2:0] squash_depth;
`ifdef PROC_SB_STATS_EN
  logic [31:0] raw_stall_cnt, waw_stall_cnt;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  proc_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_stall  (pipe_stall),
    .issue_val   (issue_val),
    .issue_rdy   (issue_rdy),
    .issue_wen   (issue_wen),
    .issue_rd    (issue_rd),
    .issue_var   (issue_var),
    .issue_lat   (issue_lat),
    .rs1_ren     (rs1_ren),
    .rs2_ren     (rs2_ren),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_byp_sel (rs1_byp_sel),
    .rs2_byp_sel (rs2_byp_sel),
    .stall       (stall),
    .var_done_val(var_done_val),
    .var_done_rd (var_done_rd),
    .wb_val      (wb_val),
    .wb_rd       (wb_rd),
    .squash_val  (squash_val),
    .squash_depth(squash_depth)
`ifdef PROC_SB_STATS_EN
    ,
    .raw_stall_cnt(raw_stall_cnt),
    .waw_stall_cnt(waw_stall_cnt)
`endif
  );

  // Step to just after the next rising edge so outputs are sampled away from it.
  task tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the D-stage issue fields for the current cycle.
  task applyStimulus(input logic val, input logic wen, input logic [4:0] rd,
                     input logic isVar, input logic [2:0] lat);
    issue_val = val;
    issue_wen = wen;
    issue_rd  = rd;
    issue_var = isVar;
    issue_lat = lat;
  endtask

  // One immediate-assertion comparison against a hand-computed value.
  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; pipe_stall = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    rs1_ren = 1'b0; rs2_ren = 1'b0; rs1_addr = '0; rs2_addr = '0;
    var_done_val = 1'b0; var_done_rd = '0; wb_val = 1'b0; wb_rd = '0;
    squash_val = 1'b0; squash_depth = '0;
    repeat (2) tick();
    reset = 1'b1;

    // Reset state
    rs1_ren = 1'b1; rs1_addr = 5'd5; rs2_ren = 1'b1; rs2_addr = 5'd9;
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_issue_rdy", issue_rdy, 1);
    checkOutput("rst_sel1", rs1_byp_sel, 0);
    checkOutput("rst_sel2", rs2_byp_sel, 0);
`ifdef PROC_SB_STATS_EN
    checkOutput("rst_raw_cnt", raw_stall_cnt, 0);
    checkOutput("rst_waw_cnt", waw_stall_cnt, 0);
`endif

    // Fixed-latency bypass walk of x5 through X/M/W then writeback
    rs2_ren = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 3'd1);
    #1;
    checkOutput("fix_issue_rdy", issue_rdy, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    #1;
    checkOutput("fix_sel_x", rs1_byp_sel, 1);
    checkOutput("fix_stall", stall, 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      checkOutput("fix_sel_adv", rs1_byp_sel, k);
      checkOutput("fix_stall_adv", stall, 0);
    end
    wb_val = 1'b1; wb_rd = 5'd5;
    tick();
    wb_val = 1'b0;
    #1;
    checkOutput("fix_sel_after_wb", rs1_byp_sel, 0);
    checkOutput("fix_stall_after_wb", stall, 0);

    // Load-use on x3 with latency 2
    rs1_ren = 1'b0; rs2_ren = 1'b1; rs2_addr = 5'd3;
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 3'd2);
    #1;
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    #1;
    checkOutput("lu_stall", stall, 1);
    checkOutput("lu_issue_rdy", issue_rdy, 0);
    tick();
    checkOutput("lu_stall_clear", stall, 0);
    checkOutput("lu_sel", rs2_byp_sel, 2);

    // Variable-latency x7, WAW block while not done
    rs2_ren = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b1, 3'd0);
    #1;
    tick();
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 3'd1);
    #1;
    checkOutput("waw_issue_rdy", issue_rdy, 0);
    checkOutput("waw_stall", stall, 1);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    rs1_ren = 1'b1; rs1_addr = 5'd7;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("var_stall", stall, 1);
      if (i < 4) tick();
    end
    var_done_val = 1'b1; var_done_rd = 5'd7;
    tick();
    var_done_val = 1'b0;
    #1;
    checkOutput("var_sel", rs1_byp_sel, 4);
    checkOutput("var_stall_clear", stall, 0);

    // pipe_stall freezes x5 at pos 2 and blocks an issue to x6
    rs1_addr = 5'd5;
    applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 3'd1);
    #1;
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    tick();
    checkOutput("ps_sel_before", rs1_byp_sel, 2);
    pipe_stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd6, 1'b0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ps_sel_frozen", rs1_byp_sel, 2);
    end
    pipe_stall = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    tick();
    checkOutput("ps_sel_resume", rs1_byp_sel, 3);
    rs2_ren = 1'b1; rs2_addr = 5'd6;
    #1;
    checkOutput("ps_no_issue", rs2_byp_sel, 0);

    // Squash: x9 at pos 1 cleared, x4 at pos 3 kept
    rs1_ren = 1'b0; rs2_ren = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd4, 1'b0, 3'd1);
    #1;
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 3'd1);
    #1;
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    rs1_ren = 1'b1; rs1_addr = 5'd9; rs2_ren = 1'b1; rs2_addr = 5'd4;
    #1;
    checkOutput("sq_pre_sel9", rs1_byp_sel, 1);
    checkOutput("sq_pre_sel4", rs2_byp_sel, 3);
    squash_val = 1'b1; squash_depth = 3'd2; pipe_stall = 1'b1;
    tick();
    squash_val = 1'b0; pipe_stall = 1'b0;
    #1;
    checkOutput("sq_sel9", rs1_byp_sel, 0);
    checkOutput("sq_sel4", rs2_byp_sel, 3);
    checkOutput("sq_stall", stall, 0);
    squash_val = 1'b1; squash_depth = 3'd1;
    applyStimulus(1'b1, 1'b1, 5'd10, 1'b0, 3'd1);
    #1;
    tick();
    squash_val = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    rs1_addr = 5'd10;
    #1;
    checkOutput("sq_issue_suppressed", rs1_byp_sel, 0);
    checkOutput("sq_sel4_adv", rs2_byp_sel, 4);

    // x0 is never pending
    rs2_ren = 1'b0; rs1_addr = 5'd0;
    applyStimulus(1'b1, 1'b1, 5'd0, 1'b1, 3'd0);
    #1;
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    #1;
    checkOutput("x0_sel", rs1_byp_sel, 0);
    checkOutput("x0_stall", stall, 0);

    // Mid-operation reset with x3, x4, x5, x7, x11 pending
    rs1_ren = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd11, 1'b1, 3'd0);
    #1;
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    rs1_ren = 1'b1; rs1_addr = 5'd11; rs2_ren = 1'b1; rs2_addr = 5'd7;
    #1;
    checkOutput("mr_pre_stall", stall, 1);
    checkOutput("mr_pre_sel7", rs2_byp_sel, 4);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("mr_stall", stall, 0);
    checkOutput("mr_issue_rdy", issue_rdy, 1);
    checkOutput("mr_sel1", rs1_byp_sel, 0);
    checkOutput("mr_sel2", rs2_byp_sel, 0);
`ifdef PROC_SB_STATS_EN
    checkOutput("mr_raw_cnt", raw_stall_cnt, 0);
    checkOutput("mr_waw_cnt", waw_stall_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
